adc_pixel_capture: RTL and testbench

- Downstream consumer of the AFE clock generator: takes the registered 5 MHz ADC clock (40 clk periods, 20 low / 20 high) and the AFE's 8-bit multiplexed output bus.
- Captures the high byte after each ADC clock rising edge and the low byte after each falling edge, then assembles 16-bit pixels.
- Counts pixels per line and buffers them in a small FIFO.
- Presents pixels on a valid/ready stream to the line buffer / DMA stage.

---
 rtl/adc_pixel_capture.sv | 188 ++++++++++++++++++
 tb/tb_adc_pixel_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pixel_capture.sv
// ADC byte-pair capture: assembles 16-bit pixels from the AFE mux bus and streams them out via a small FIFO.
// Optional incrementing test pattern is compiled in when ADC_PIXEL_CAPTURE_TESTPAT_EN is defined.
module adc_pixel_capture #(
   parameter int SAMPLE_DLY   = 10,
   parameter int PIX_PER_LINE = 2048,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adcclk,
   input  logic [7:0]  adc_data,
   input  logic        start,
   input  logic        test_mode,
   output logic        busy,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        line_done,
   output logic        overflow
);

   localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]    TMR_LOAD = 5'(SAMPLE_DLY - 1);
   localparam logic [15:0]   LAST_PIX = 16'(PIX_PER_LINE - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAPT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          adcclk_q;
   logic          rise, fall;
   logic [4:0]    tmr_q;
   logic          tmr_run_q;
   logic          tmr_hi_q;
   logic          fire, hi_fire, lo_fire;
   logic [7:0]    hi_byte_q;
   logic [15:0]   pix_cnt_q;
   logic [15:0]   word;
   logic          wr_req, last_pix;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d, cnt_after_rd;
   logic [15:0]   pix_data_q, head_d;
   logic          overflow_q;
   logic          full, rd_en, wr_en;

   assign rise    = adcclk & ~adcclk_q;
   assign fall    = ~adcclk & adcclk_q;
   assign fire    = tmr_run_q && (tmr_q == 5'd0);
   assign hi_fire = fire & tmr_hi_q;
   assign lo_fire = fire & ~tmr_hi_q;

   // Any edge restarts the timer; the edge type decides which byte the fire samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         adcclk_q  <= 1'b0;
         tmr_q     <= 5'd0;
         tmr_run_q <= 1'b0;
         tmr_hi_q  <= 1'b0;
         hi_byte_q <= 8'd0;
      end else begin
         adcclk_q <= adcclk;
         if (rise || fall) begin
            tmr_q     <= TMR_LOAD;
            tmr_run_q <= 1'b1;
            tmr_hi_q  <= rise;
         end else if (fire) begin
            tmr_run_q <= 1'b0;
         end else if (tmr_run_q) begin
            tmr_q <= tmr_q - 5'd1;
         end
         if (hi_fire) begin
            hi_byte_q <= adc_data;
         end
      end
   end

   assign wr_req   = (state_q == S_CAPT) && lo_fire;
   assign last_pix = wr_req && (pix_cnt_q == LAST_PIX);

`ifdef ADC_PIXEL_CAPTURE_TESTPAT_EN
   logic [15:0] pat_q;

   always_ff @(posedge clk) begin
      if (rst || state_q == S_IDLE) begin
         pat_q <= 16'd0;
      end else if (wr_req) begin
         pat_q <= pat_q + 16'd1;
      end
   end

   assign word = test_mode ? pat_q : {hi_byte_q, adc_data};
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign word = {hi_byte_q, adc_data};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Entering CAPT only on a rise guarantees every low byte has a high byte from its own period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SYNC;
         S_SYNC:  if (rise) state_d = S_CAPT;
         S_CAPT:  if (last_pix) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      line_done = 1'b0;
      case (state_q)
         S_SYNC:  busy = 1'b1;
         S_CAPT:  busy = 1'b1;
         S_DONE:  line_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt_q <= 16'd0;
      end else if (last_pix) begin
         pix_cnt_q <= 16'd0;
      end else if (wr_req) begin
         pix_cnt_q <= pix_cnt_q + 16'd1;
      end
   end

   assign full  = (cnt_q == FULL_CNT);
   assign rd_en = pix_valid && pix_ready;
   assign wr_en = wr_req && (!full || rd_en);

   always_comb begin
      wr_ptr_d     = wr_ptr_q + AW'(wr_en);
      rd_ptr_d     = rd_ptr_q + AW'(rd_en);
      cnt_after_rd = cnt_q - (AW + 1)'(rd_en);
      cnt_d        = cnt_after_rd + (AW + 1)'(wr_en);
      // A word written into an (effectively) empty FIFO becomes the head directly.
      if (wr_en && cnt_after_rd == '0) begin
         head_d = word;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         pix_data_q <= 16'd0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (cnt_d != '0) begin
            pix_data_q <= head_d;
         end
         if (wr_req && full && !rd_en) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign pix_valid = (cnt_q != '0);
   assign pix_data  = pix_data_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_adc_pixel_capture.sv
// Directed bench for adc_pixel_capture: ADC/AFE model, expected-pixel queue, stream monitor.
module tb_adc_pixel_capture;

   localparam int PPL   = 6;
   localparam int DEPTH = 4;
   localparam int DLY   = 10;
`ifdef ADC_PIXEL_CAPTURE_TESTPAT_EN
   localparam bit PAT_ON = 1'b1;
`else
   localparam bit PAT_ON = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        adcclk    = 1'b0;
   logic [7:0]  adc_data  = 8'd0;
   logic        start     = 1'b0;
   logic        test_mode = 1'b0;
   logic        pix_ready = 1'b0;
   logic        busy;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        line_done;
   logic        overflow;

   int          checks   = 0;
   int          failures = 0;
   int          ph       = 20;
   int          per_n    = 0;
   int          rx_cnt   = 0;
   int          ld_cnt   = 0;
   logic        ld_busy  = 1'b1;
   logic        ld_valid = 1'b0;
   logic [15:0] exp_q[$];

   adc_pixel_capture #(
      .SAMPLE_DLY  (DLY),
      .PIX_PER_LINE(PPL),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .adcclk   (adcclk),
      .adc_data (adc_data),
      .start    (start),
      .test_mode(test_mode),
      .busy     (busy),
      .pix_data (pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .line_done(line_done),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ADC clock: 20 cycles high (high byte of period n), 20 low (low byte of period n).
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ph = (ph == 39) ? 0 : ph + 1;
         if (ph == 0) per_n++;
         adcclk   = (ph < 20);
         adc_data = adcclk ? 8'(8'hA0 + per_n) : 8'(8'h50 + per_n);
      end
   end

   // Stream monitor: pops the expected queue on every accepted pixel.
   initial begin
      logic [15:0] expv;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (pix_valid && pix_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pixel", 32'(pix_data), 32'hFFFF_FFFF);
               end else begin
                  expv = exp_q.pop_front();
                  check("pix_data", 32'(pix_data), 32'(expv));
               end
               rx_cnt++;
               $display("pixel %0d data=%04h", rx_cnt, pix_data);
            end
            if (line_done) begin
               ld_cnt++;
               ld_busy  = busy;
               ld_valid = pix_valid;
               $display("line_done %0d busy=%0b", ld_cnt, busy);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_line(input int phase, input int npush, input bit pat);
      int base;
      int guard;
      guard = 0;
      while (ph != phase && guard < 100) begin
         tick();
         guard++;
      end
      base = per_n;
      for (int k = 1; k <= npush; k++) begin
         if (pat) exp_q.push_back(16'(k - 1));
         else     exp_q.push_back({8'(8'hA0 + base + k), 8'(8'h50 + base + k)});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int ld0;
      int i;
      ld0 = ld_cnt;
      i   = 0;
      while (ld_cnt == ld0 && i < 2000) begin
         tick();
         i++;
      end
      check(tag, 32'(ld_cnt - ld0), 32'd1);
   endtask

   initial begin
      int rx0;
      int ld0;
      int i;

      repeat (4) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_line_done", 32'(line_done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_pix_data", 32'(pix_data), 32'd0);
      rst = 1'b0;
      tick();

      // Basic capture, start in the high phase
      pix_ready = 1'b1;
      rx0 = rx_cnt;
      start_line(5, PPL, 1'b0);
      check("t1_busy_after_start", 32'(busy), 32'd1);
      wait_done("t1_done");
      check("t1_busy_at_done", 32'(ld_busy), 32'd0);
      check("t1_valid_at_done", 32'(ld_valid), 32'd1);
      repeat (5) tick();
      check("t1_rx_count", 32'(rx_cnt - rx0), 32'(PPL));
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

      // Sync alignment, start in the low phase
      rx0 = rx_cnt;
      start_line(25, PPL, 1'b0);
      wait_done("t2_done");
      repeat (5) tick();
      check("t2_rx_count", 32'(rx_cnt - rx0), 32'(PPL));
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure and overflow
      pix_ready = 1'b0;
      rx0 = rx_cnt;
      start_line(5, DEPTH, 1'b0);
      check("t3_overflow_before", 32'(overflow), 32'd0);
      wait_done("t3_done");
      check("t3_overflow_set", 32'(overflow), 32'd1);
      check("t3_valid_held", 32'(pix_valid), 32'd1);
      check("t3_head_held", 32'(pix_data), 32'(exp_q[0]));
      check("t3_no_rx", 32'(rx_cnt - rx0), 32'd0);
      pix_ready = 1'b1;
      repeat (10) tick();
      check("t3_drain_count", 32'(rx_cnt - rx0), 32'(DEPTH));
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t3_valid_after", 32'(pix_valid), 32'd0);
      check("t3_overflow_sticky", 32'(overflow), 32'd1);

      // Start while busy
      rx0 = rx_cnt;
      ld0 = ld_cnt;
      start_line(5, PPL, 1'b0);
      repeat (100) tick();
      check("t4_busy_mid", 32'(busy), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t4_done");
      repeat (300) tick();
      check("t4_one_line_done", 32'(ld_cnt - ld0), 32'd1);
      check("t4_rx_count", 32'(rx_cnt - rx0), 32'(PPL));
      check("t4_idle", 32'(busy), 32'd0);

      // Reset mid-line
      rx0 = rx_cnt;
      start_line(5, PPL, 1'b0);
      i = 0;
      while (rx_cnt - rx0 < 2 && i < 1000) begin
         tick();
         i++;
      end
      check("t5_two_pixels", 32'(rx_cnt - rx0), 32'd2);
      rst = 1'b1;
      tick();
      tick();
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_valid", 32'(pix_valid), 32'd0);
      check("t5_overflow", 32'(overflow), 32'd0);
      check("t5_line_done", 32'(line_done), 32'd0);
      check("t5_pix_data", 32'(pix_data), 32'd0);
      exp_q.delete();
      rst = 1'b0;
      tick();
      rx0 = rx_cnt;
      start_line(5, PPL, 1'b0);
      wait_done("t5_fresh_done");
      repeat (5) tick();
      check("t5_fresh_rx", 32'(rx_cnt - rx0), 32'(PPL));
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // Test pattern (plain capture when the feature is compiled out)
      test_mode = 1'b1;
      rx0 = rx_cnt;
      for (int ln = 0; ln < 2; ln++) begin
         start_line(5, PPL, PAT_ON);
         wait_done("t6_done");
         repeat (5) tick();
      end
      test_mode = 1'b0;
      check("t6_rx_count", 32'(rx_cnt - rx0), 32'(2 * PPL));
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
